// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-ported, multi-cycle memory between the fetch stage
//   (instruction reads) and the memory stage (data loads/stores). A request
//   is latched at grant time, exactly one memory command is issued, and the
//   owner receives a one-cycle done pulse with its read data.
//
//   Data requests normally win arbitration. After STARVE_LIM consecutive data
//   grants made while fetch was waiting, fetch wins the next arbitration.
//   While halt is high, no new fetch is granted.
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   i_req/i_addr             fetch read request and address
//   i_rdata/i_done/i_stall   fetch read data, completion pulse, hold
//   d_rd/d_wr/d_addr/d_wdata data load/store request, address, store data
//   d_rdata/d_done/d_stall   load data, completion pulse, hold
//   halt                     blocks new fetch grants
//   mem_addr/mem_wdata       memory command address and write data
//   mem_rd/mem_wr            memory read/write command
//   mem_stall                memory cannot accept the command this cycle
//   mem_done/mem_rdata       memory completion pulse and read data
//   err                      sticky: d_rd and d_wr were granted together

module mem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_done,
    output logic              i_stall,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              d_stall,
    input  logic              halt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic              mem_stall,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} stateType;
    typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_DATA} ownerType;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIM);

    stateType          state;
    stateType          nextState;
    ownerType          owner;
    logic [3:0]        starveCnt;
    logic [ADDR_W-1:0] addrReg;
    logic [DATA_W-1:0] wdataReg;
    logic [DATA_W-1:0] iRdataReg;
    logic [DATA_W-1:0] dRdataReg;
    logic              opWrite;
    logic              errReg;

    logic              dataReq;
    logic              grantData;
    logic              grantFetch;
    logic              capture;

    // Arbitration is only evaluated in IDLE. Data wins unless fetch has been
    // starved long enough; a lone data request is still served even when the
    // starvation limit has been reached (fetch absent or halted).
    always_comb begin
        dataReq    = d_rd | d_wr;
        grantData  = 1'b0;
        grantFetch = 1'b0;
        if (state == IDLE) begin
            if (dataReq && (starveCnt < STARVE_MAX)) begin
                grantData = 1'b1;
            end else if (i_req && !halt) begin
                grantFetch = 1'b1;
            end else if (dataReq) begin
                grantData = 1'b1;
            end
        end
    end

    // Next-state logic. A completion seen while the command is still in
    // ISSUE is taken directly, so a fast memory never loses its response.
    always_comb begin
        nextState = state;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (grantData || grantFetch) begin
                    nextState = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_done) begin
                    capture   = 1'b1;
                    nextState = RESP;
                end else if (!mem_stall) begin
                    nextState = WAIT;
                end
            end
            WAIT: begin
                if (mem_done) begin
                    capture   = 1'b1;
                    nextState = RESP;
                end
            end
            RESP: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // State register; reset abandons any in-flight command without a done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Starvation counter: counts data grants that overtook a waiting,
    // un-halted fetch. Any fetch grant or an absent fetch request resets it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starveCnt <= 4'd0;
        end else if (!i_req || grantFetch) begin
            starveCnt <= 4'd0;
        end else if (grantData && !halt && (starveCnt < STARVE_MAX)) begin
            starveCnt <= starveCnt + 4'd1;
        end
    end

    // Grant-time latching of the request and capture of the response.
    // A simultaneous load/store is performed as a store and flagged.
    // Stores leave the load data register untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner     <= OWN_NONE;
            addrReg   <= '0;
            wdataReg  <= '0;
            opWrite   <= 1'b0;
            iRdataReg <= '0;
            dRdataReg <= '0;
            errReg    <= 1'b0;
        end else begin
            if (grantData) begin
                owner    <= OWN_DATA;
                addrReg  <= d_addr;
                wdataReg <= d_wdata;
                opWrite  <= d_wr;
                if (d_rd && d_wr) begin
                    errReg <= 1'b1;
                end
            end else if (grantFetch) begin
                owner   <= OWN_FETCH;
                addrReg <= i_addr;
                opWrite <= 1'b0;
            end else if (state == RESP) begin
                owner <= OWN_NONE;
            end
            if (capture) begin
                if (owner == OWN_FETCH) begin
                    iRdataReg <= mem_rdata;
                end else if ((owner == OWN_DATA) && !opWrite) begin
                    dRdataReg <= mem_rdata;
                end
            end
        end
    end

    assign mem_addr  = addrReg;
    assign mem_wdata = wdataReg;
    assign mem_rd    = (state == ISSUE) && !opWrite;
    assign mem_wr    = (state == ISSUE) && opWrite;
    assign i_done    = (state == RESP) && (owner == OWN_FETCH);
    assign d_done    = (state == RESP) && (owner == OWN_DATA);
    assign i_rdata   = iRdataReg;
    assign d_rdata   = dRdataReg;
    assign i_stall   = i_req & ~i_done;
    assign d_stall   = dataReq & ~d_done;
    assign err       = errReg;

endmodule
